// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the FIFO, absorbs its 1-cycle read latency and presents a
// valid/ready stream with line/frame markers through a 2-entry skid buffer.

module fifo_rd_stream_chk (
   input logic       I_clk,
   input logic       I_rst_n,
   input logic       fifo_rempty_s,
   input logic       fifo_rinc_s,
   input logic [1:0] occ_s,
   input logic       cap_s,
   input logic       take_s
);

   a_no_pop_when_empty : assert property (@(posedge I_clk) disable iff (!I_rst_n)
      !(fifo_rinc_s && fifo_rempty_s));

   a_occ_in_range : assert property (@(posedge I_clk) disable iff (!I_rst_n)
      occ_s != 2'd3);

   a_no_skid_overflow : assert property (@(posedge I_clk) disable iff (!I_rst_n)
      !(cap_s && !take_s && (occ_s == 2'd2)));

endmodule

module fifo_rd_stream #(
   parameter int DSIZE = 8,
   parameter int LEN_W = 16
) (
   input  logic             I_clk,
   input  logic             I_rst_n,
   input  logic [LEN_W-1:0] I_beats_per_line,
   input  logic [LEN_W-1:0] I_lines_per_frame,
   input  logic             I_fifo_rempty,
   input  logic [DSIZE-1:0] I_fifo_rdata,
   output logic             O_fifo_rinc,
   output logic             O_valid,
   input  logic             I_ready,
   output logic [DSIZE-1:0] O_data,
   output logic             O_last,
   output logic             O_sof,
   output logic             O_eof,
   output logic             O_busy
);

   // Entry layout: {sof, eof, last, data}
   localparam int EW     = DSIZE + 3;
   localparam int LAST_B = DSIZE;
   localparam int EOF_B  = DSIZE + 1;
   localparam int SOF_B  = DSIZE + 2;

   logic [EW-1:0]    slot0_r, slot1_r, slot0_n, slot1_n;
   logic [1:0]       occ_r, occ_n;
   logic             inflight_r;
   logic             valid_r;
   logic             busy_r;
   logic [LEN_W-1:0] cap_beat_r, cap_line_r, cap_beat_n, cap_line_n;
   logic [LEN_W-1:0] tk_beat_r, tk_line_r, tk_beat_n, tk_line_n;
   logic [LEN_W-1:0] bpl_m1_s, lpf_m1_s;
   logic [2:0]       level_s;
   logic             take_s, cap_s, rinc_s;
   logic             cap_last_s, cap_eof_s, cap_sof_s;
   logic [EW-1:0]    new_entry_s;

   // Terminal counts, with a zero size treated as one
   always_comb begin
      if (I_beats_per_line == '0) begin
         bpl_m1_s = '0;
      end else begin
         bpl_m1_s = I_beats_per_line - LEN_W'(1);
      end
      if (I_lines_per_frame == '0) begin
         lpf_m1_s = '0;
      end else begin
         lpf_m1_s = I_lines_per_frame - LEN_W'(1);
      end
   end

   assign take_s  = valid_r & I_ready;
   assign cap_s   = inflight_r;
   assign level_s = {1'b0, occ_r} + {2'b00, inflight_r};
   // Pop only if the word will have a free slot when it lands next cycle
   assign rinc_s  = I_rst_n & ~I_fifo_rempty & (level_s < (3'd2 + {2'b00, take_s}));
   assign O_fifo_rinc = rinc_s;

   // Framing flags for the word being captured this cycle
   always_comb begin
      cap_last_s  = (cap_beat_r == bpl_m1_s);
      cap_eof_s   = cap_last_s && (cap_line_r == lpf_m1_s);
      cap_sof_s   = (cap_beat_r == '0) && (cap_line_r == '0);
      new_entry_s = {cap_sof_s, cap_eof_s, cap_last_s, I_fifo_rdata};
   end

   // Skid buffer next state: slot0 is always the head
   always_comb begin
      slot0_n = slot0_r;
      slot1_n = slot1_r;
      occ_n   = occ_r;
      case ({cap_s, take_s})
         2'b01: begin
            slot0_n = slot1_r;
            slot1_n = '0;
            occ_n   = occ_r - 2'd1;
         end
         2'b10: begin
            if (occ_r == 2'd0) begin
               slot0_n = new_entry_s;
            end else begin
               slot1_n = new_entry_s;
            end
            occ_n = occ_r + 2'd1;
         end
         2'b11: begin
            if (occ_r == 2'd1) begin
               slot0_n = new_entry_s;
            end else begin
               slot0_n = slot1_r;
               slot1_n = new_entry_s;
            end
         end
         default: begin
            occ_n = occ_r;
         end
      endcase
   end

   // Capture-side counters advance per word entering the buffer
   always_comb begin
      cap_beat_n = cap_beat_r;
      cap_line_n = cap_line_r;
      if (cap_s) begin
         if (cap_last_s) begin
            cap_beat_n = '0;
            if (cap_eof_s) begin
               cap_line_n = '0;
            end else begin
               cap_line_n = cap_line_r + LEN_W'(1);
            end
         end else begin
            cap_beat_n = cap_beat_r + LEN_W'(1);
         end
      end else begin
         cap_beat_n = cap_beat_r;
      end
   end

   // Take-side counters advance per accepted beat and drive O_busy
   always_comb begin
      tk_beat_n = tk_beat_r;
      tk_line_n = tk_line_r;
      if (take_s) begin
         if (slot0_r[LAST_B]) begin
            tk_beat_n = '0;
            if (slot0_r[EOF_B]) begin
               tk_line_n = '0;
            end else begin
               tk_line_n = tk_line_r + LEN_W'(1);
            end
         end else begin
            tk_beat_n = tk_beat_r + LEN_W'(1);
         end
      end else begin
         tk_beat_n = tk_beat_r;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         slot0_r    <= '0;
         slot1_r    <= '0;
         occ_r      <= 2'd0;
         inflight_r <= 1'b0;
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
         cap_beat_r <= '0;
         cap_line_r <= '0;
         tk_beat_r  <= '0;
         tk_line_r  <= '0;
      end else begin
         slot0_r    <= slot0_n;
         slot1_r    <= slot1_n;
         occ_r      <= occ_n;
         inflight_r <= rinc_s;
         valid_r    <= (occ_n != 2'd0);
         busy_r     <= (tk_beat_n != '0) || (tk_line_n != '0);
         cap_beat_r <= cap_beat_n;
         cap_line_r <= cap_line_n;
         tk_beat_r  <= tk_beat_n;
         tk_line_r  <= tk_line_n;
      end
   end

   assign O_valid = valid_r;
   assign O_data  = slot0_r[DSIZE-1:0];
   assign O_last  = slot0_r[LAST_B];
   assign O_eof   = slot0_r[EOF_B];
   assign O_sof   = slot0_r[SOF_B];
   assign O_busy  = busy_r;

   fifo_rd_stream_chk u_chk (
      .I_clk         (I_clk),
      .I_rst_n       (I_rst_n),
      .fifo_rempty_s (I_fifo_rempty),
      .fifo_rinc_s   (rinc_s),
      .occ_s         (occ_r),
      .cap_s         (cap_s),
      .take_s        (take_s)
   );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a 1-cycle-latency FIFO model.
module tb_fifo_rd_stream;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] bpl, lpf;
   logic        fifo_rempty;
   logic [7:0]  fifo_rdata;
   logic        fifo_rinc;
   logic        valid, ready;
   logic [7:0]  data;
   logic        last, sof, eof, busy;
   logic        fifo_clr;

   logic [7:0]  fmem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DSIZE(8), .LEN_W(16)) dut (
      .I_clk             (clk),
      .I_rst_n           (rst_n),
      .I_beats_per_line  (bpl),
      .I_lines_per_frame (lpf),
      .I_fifo_rempty     (fifo_rempty),
      .I_fifo_rdata      (fifo_rdata),
      .O_fifo_rinc       (fifo_rinc),
      .O_valid           (valid),
      .I_ready           (ready),
      .O_data            (data),
      .O_last            (last),
      .O_sof             (sof),
      .O_eof             (eof),
      .O_busy            (busy)
   );

   assign fifo_rempty = (wr_ptr == rd_ptr);

   // FIFO model: data appears on rdata the cycle after a pop
   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_ptr     <= wr_ptr;
         fifo_rdata <= 8'h00;
      end else if (fifo_rinc && (rd_ptr != wr_ptr)) begin
         fifo_rdata <= fmem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [7:0] v);
      fmem[wr_ptr] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   function automatic logic [10:0] beat(input logic s, input logic l, input logic e,
                                        input logic [7:0] d);
      return {s, l, e, d};
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; ready = 1'b1; bpl = 16'd4; lpf = 16'd2; fifo_clr = 1'b0;
      push(8'hA5);
      push(8'h5A);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (fifo_rinc !== 1'b0)
            begin n_fail++; $display("FAIL reset_rinc cyc%0d: got %b expected 0", i, fifo_rinc); end
      end
      n_tests++;
      if ({valid, data, last, sof, eof, busy} !== 13'h0000)
         begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {valid, data, last, sof, eof, busy}); end
      fifo_clr = 1'b1;
      @(negedge clk);
      fifo_clr = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_stream;
      logic [10:0] exp_b;
      bpl = 16'd4; lpf = 16'd2; ready = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
      #1;
      n_tests++;
      if (fifo_rinc !== 1'b1)
         begin n_fail++; $display("FAIL stream_first_pop: got %b expected 1", fifo_rinc); end
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b0)
         begin n_fail++; $display("FAIL stream_valid_early: got %b expected 0", valid); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_b = beat(i == 0, (i % 4) == 3, i == 7, 8'(8'h10 + i));
         n_tests++;
         if (valid !== 1'b1 || {sof, last, eof, data} !== exp_b)
            begin n_fail++; $display("FAIL stream_beat%0d: got v=%b %h expected v=1 %h", i, valid, {sof, last, eof, data}, exp_b); end
         if (i == 2) begin
            n_tests++;
            if (busy !== 1'b1)
               begin n_fail++; $display("FAIL stream_busy: got %b expected 1", busy); end
         end
      end
      @(negedge clk);
      n_tests++;
      if (valid !== 1'b0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL stream_end: got v=%b busy=%b expected 0 0", valid, busy); end
   endtask

   task automatic test_backpressure;
      int          pops, takes;
      logic        prev_stall;
      logic [10:0] prev_b, exp_b;
      pops = 0; takes = 0; prev_stall = 1'b0; prev_b = '0;
      bpl = 16'd4; lpf = 16'd2;
      for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
      for (int c = 0; c < 200 && takes < 16; c++) begin
         ready = (c >= 6 && c <= 10) ? 1'b0 : ((c % 2) == 0);
         #1;
         if (prev_stall) begin
            n_tests++;
            if (valid !== 1'b1 || {sof, last, eof, data} !== prev_b)
               begin n_fail++; $display("FAIL bp_hold c%0d: got v=%b %h expected v=1 %h", c, valid, {sof, last, eof, data}, prev_b); end
         end
         if (fifo_rinc === 1'b1) begin
            pops++;
            n_tests++;
            if (fifo_rempty !== 1'b0)
               begin n_fail++; $display("FAIL bp_pop_empty c%0d: got rempty=%b expected 0", c, fifo_rempty); end
         end
         if (valid === 1'b1 && ready === 1'b1) begin
            exp_b = beat((takes % 8) == 0, (takes % 4) == 3, (takes % 8) == 7, 8'(8'h30 + takes));
            n_tests++;
            if ({sof, last, eof, data} !== exp_b)
               begin n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", takes, {sof, last, eof, data}, exp_b); end
            takes++;
         end
         n_tests++;
         if (pops - takes > 2)
            begin n_fail++; $display("FAIL bp_occupancy c%0d: got %0d expected <=2", c, pops - takes); end
         prev_stall = (valid === 1'b1) && (ready === 1'b0);
         prev_b = {sof, last, eof, data};
         @(negedge clk);
      end
      n_tests++;
      if (takes != 16 || valid !== 1'b0 || busy !== 1'b0)
         begin n_fail++; $display("FAIL bp_done: got takes=%0d v=%b busy=%b expected 16 0 0", takes, valid, busy); end
      ready = 1'b1;
   endtask

   task automatic test_underflow;
      int          takes;
      logic [10:0] got [0:7];
      takes = 0;
      bpl = 16'd4; lpf = 16'd1; ready = 1'b1;
      push(8'h40); push(8'h41); push(8'h42);
      for (int c = 0; c < 10; c++) begin
         #1;
         if (valid === 1'b1 && takes < 8) begin got[takes] = {sof, last, eof, data}; takes++; end
         @(negedge clk);
      end
      n_tests++;
      if (takes != 3)
         begin n_fail++; $display("FAIL uf_count: got %0d expected 3", takes); end
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (got[k] !== beat(k == 0, 1'b0, 1'b0, 8'(8'h40 + k)))
            begin n_fail++; $display("FAIL uf_beat%0d: got %h expected %h", k, got[k], beat(k == 0, 1'b0, 1'b0, 8'(8'h40 + k))); end
      end
      n_tests++;
      if (valid !== 1'b0 || fifo_rinc !== 1'b0 || busy !== 1'b1)
         begin n_fail++; $display("FAIL uf_idle: got v=%b rinc=%b busy=%b expected 0 0 1", valid, fifo_rinc, busy); end
      push(8'h43);
      takes = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (valid === 1'b1 && takes < 8) begin got[takes] = {sof, last, eof, data}; takes++; end
         @(negedge clk);
      end
      n_tests++;
      if (takes != 1 || got[0] !== beat(1'b0, 1'b1, 1'b1, 8'h43))
         begin n_fail++; $display("FAIL uf_tail: got n=%0d %h expected n=1 %h", takes, got[0], beat(1'b0, 1'b1, 1'b1, 8'h43)); end
      n_tests++;
      if (busy !== 1'b0)
         begin n_fail++; $display("FAIL uf_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_degenerate;
      int takes;
      takes = 0;
      bpl = 16'd0; lpf = 16'd0; ready = 1'b1;
      push(8'h50); push(8'h51); push(8'h52);
      for (int c = 0; c < 8; c++) begin
         #1;
         n_tests++;
         if (busy !== 1'b0)
            begin n_fail++; $display("FAIL deg_busy c%0d: got %b expected 0", c, busy); end
         if (valid === 1'b1) begin
            n_tests++;
            if ({sof, last, eof, data} !== beat(1'b1, 1'b1, 1'b1, 8'(8'h50 + takes)))
               begin n_fail++; $display("FAIL deg_beat%0d: got %h expected %h", takes, {sof, last, eof, data}, beat(1'b1, 1'b1, 1'b1, 8'(8'h50 + takes))); end
            takes++;
         end
         @(negedge clk);
      end
      n_tests++;
      if (takes != 3)
         begin n_fail++; $display("FAIL deg_count: got %0d expected 3", takes); end
   endtask

   task automatic test_midreset;
      int          takes;
      logic [10:0] got [0:7];
      takes = 0;
      bpl = 16'd4; lpf = 16'd1; ready = 1'b1;
      for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
      for (int c = 0; c < 12 && takes < 2; c++) begin
         #1;
         if (valid === 1'b1) begin got[takes] = {sof, last, eof, data}; takes++; end
         @(negedge clk);
      end
      n_tests++;
      if (takes != 2 || got[0] !== beat(1'b1, 1'b0, 1'b0, 8'h60) || got[1] !== beat(1'b0, 1'b0, 1'b0, 8'h61))
         begin n_fail++; $display("FAIL mr_pre: got n=%0d %h %h expected n=2 %h %h", takes, got[0], got[1], beat(1'b1, 1'b0, 1'b0, 8'h60), beat(1'b0, 1'b0, 1'b0, 8'h61)); end
      rst_n = 1'b0; fifo_clr = 1'b1; ready = 1'b0;
      #1;
      n_tests++;
      if (fifo_rinc !== 1'b0)
         begin n_fail++; $display("FAIL mr_rinc: got %b expected 0", fifo_rinc); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++;
         if ({valid, data, last, sof, eof, busy, fifo_rinc} !== 14'h0000)
            begin n_fail++; $display("FAIL mr_reset%0d: got %h expected 0", i, {valid, data, last, sof, eof, busy, fifo_rinc}); end
      end
      rst_n = 1'b1; fifo_clr = 1'b0; ready = 1'b1;
      push(8'h20); push(8'h21);
      takes = 0;
      for (int c = 0; c < 8 && takes < 1; c++) begin
         #1;
         if (valid === 1'b1) begin got[0] = {sof, last, eof, data}; takes++; end
         @(negedge clk);
      end
      n_tests++;
      if (takes != 1 || got[0] !== beat(1'b1, 1'b0, 1'b0, 8'h20))
         begin n_fail++; $display("FAIL mr_first: got n=%0d %h expected n=1 %h", takes, got[0], beat(1'b1, 1'b0, 1'b0, 8'h20)); end
   endtask

   initial begin
      rst_n = 1'b0; ready = 1'b0; fifo_clr = 1'b0; bpl = 16'd4; lpf = 16'd2;
      test_reset();
      test_stream();
      test_backpressure();
      test_underflow();
      test_degenerate();
      test_midreset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
